// File: rtl/kbd_event_fifo.sv
// ============================================================================
// Module   : kbd_event_fifo
// Function : PS/2 scan-byte fetcher, E0/F0 prefix folder and show-ahead event
//            FIFO for the CPU keyboard read port.
// Option   : KBD_TYPEMATIC_FILTER_EN - suppress auto-repeat of a held key.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    kb_data,
   input  logic          kb_ready,
   output logic          ps2_rdn,
   input  logic          cpu_rd,
   output logic [15:0]   cpu_rdata,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [0:0] F_IDLE = 1'b0;
   localparam logic [0:0] F_WAIT = 1'b1;

   localparam logic [1:0] P_BASE = 2'b00;
   localparam logic [1:0] P_E0   = 2'b01;
   localparam logic [1:0] P_F0   = 2'b10;
   localparam logic [1:0] P_E0F0 = 2'b11;

   localparam logic [7:0] c_byte_e0  = 8'hE0;
   localparam logic [7:0] c_byte_f0  = 8'hF0;
   localparam logic [7:0] c_byte_err = 8'h00;
   localparam logic [7:0] c_byte_ovr = 8'hFF;

   localparam logic [AW:0]   c_full     = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] c_ptr_one  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   c_cnt_one  = {{AW{1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Fetch FSM
   // ------------------------------------------------------------------------
   logic [0:0] r_fstate;
   logic [7:0] r_byte;
   logic       r_ps2_rdn;
   logic       w_byte_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fstate  <= F_IDLE;
         r_ps2_rdn <= 1'b1;
         r_byte    <= 8'h00;
      end else begin
         case (r_fstate)
            F_IDLE: begin
               r_ps2_rdn <= 1'b1;
               if (kb_ready) begin
                  r_byte    <= kb_data;
                  r_ps2_rdn <= 1'b0;
                  r_fstate  <= F_WAIT;
               end
            end
            default: begin
               r_ps2_rdn <= 1'b1;
               r_fstate  <= F_IDLE;
            end
         endcase
      end
   end

   // The latched byte is consumed during the pop-pulse cycle.
   assign w_byte_vld = (r_fstate == F_WAIT);
   assign ps2_rdn    = r_ps2_rdn;

   // ------------------------------------------------------------------------
   // Prefix FSM
   // ------------------------------------------------------------------------
   logic [1:0] r_pstate;
   logic [1:0] w_pnext;
   logic       w_emit;
   logic       w_evt_rel;
   logic       w_evt_ext;
   logic [7:0] w_evt_code;

   always_comb begin
      w_pnext    = r_pstate;
      w_emit     = 1'b0;
      w_evt_rel  = (r_pstate == P_F0) || (r_pstate == P_E0F0);
      w_evt_ext  = (r_pstate == P_E0) || (r_pstate == P_E0F0);
      w_evt_code = r_byte;
      if (w_byte_vld) begin
         if ((r_byte == c_byte_err) || (r_byte == c_byte_ovr)) begin
            w_pnext = P_BASE;
         end else if (r_byte == c_byte_e0) begin
            w_pnext = P_E0;
         end else if (r_byte == c_byte_f0) begin
            if (r_pstate == P_BASE) begin
               w_pnext = P_F0;
            end else if (r_pstate == P_E0) begin
               w_pnext = P_E0F0;
            end
         end else begin
            w_emit  = 1'b1;
            w_pnext = P_BASE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pstate <= P_BASE;
      end else begin
         r_pstate <= w_pnext;
      end
   end

   // ------------------------------------------------------------------------
   // Optional typematic filter
   // ------------------------------------------------------------------------
   logic w_suppress;

`ifdef KBD_TYPEMATIC_FILTER_EN
   logic       r_held_vld;
   logic       r_held_ext;
   logic [7:0] r_held_code;
   logic       w_held_match;

   assign w_held_match = r_held_vld && (r_held_ext == w_evt_ext) &&
                         (r_held_code == w_evt_code);
   assign w_suppress   = w_emit && !w_evt_rel && w_held_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_held_vld  <= 1'b0;
         r_held_ext  <= 1'b0;
         r_held_code <= 8'h00;
      end else if (w_emit) begin
         if (!w_evt_rel) begin
            r_held_vld  <= 1'b1;
            r_held_ext  <= w_evt_ext;
            r_held_code <= w_evt_code;
         end else if (w_held_match) begin
            r_held_vld  <= 1'b0;
         end
      end
   end
`else
   assign w_suppress = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------------
   logic [9:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_wr;
   logic          w_drop;
   logic          w_nonempty;

   assign w_nonempty = (r_count != '0);
   assign w_full     = (r_count == c_full);
   assign w_push     = w_emit && !w_suppress;
   assign w_pop      = cpu_rd && w_nonempty;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
   assign w_wr       = w_push && (!w_full || w_pop);
   assign w_drop     = w_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= {w_evt_rel, w_evt_ext, w_evt_code};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (w_pop) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign cpu_rdata = w_nonempty ? {1'b1, 5'b00000, r_mem[r_rptr]} : 16'h0000;
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_fifo.sv
// ============================================================================
// Module   : tb_kbd_event_fifo
// Function : Scoreboard bench for kbd_event_fifo (honours KBD_TYPEMATIC_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_event_fifo;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk;
   logic          rst;
   logic [7:0]    kb_data;
   logic          kb_ready;
   logic          ps2_rdn;
   logic          cpu_rd;
   logic [15:0]   cpu_rdata;
   logic [AW:0]   count;
   logic          overflow;

   int            n_cmp;
   int            n_err;
   logic [15:0]   exp_q[$];

   kbd_event_fifo #(.DEPTH(DEPTH), .AW(AW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .kb_data   (kb_data),
      .kb_ready  (kb_ready),
      .ps2_rdn   (ps2_rdn),
      .cpu_rd    (cpu_rd),
      .cpu_rdata (cpu_rdata),
      .count     (count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Tasks start and end just after a falling edge.
   task automatic send_byte(input logic [7:0] b);
      kb_data  = b;
      kb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rdn_low", 32'(ps2_rdn), 32'd0);
      kb_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rdn_high", 32'(ps2_rdn), 32'd1);
   endtask

   // Byte fetch with a CPU pop landing on the same edge as the push.
   task automatic send_byte_pop(input logic [7:0] b, input logic [15:0] ev);
      logic [15:0] e;
      kb_data  = b;
      kb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kb_ready = 1'b0;
      e = exp_q.pop_front();
      chk("head_pp", 32'(cpu_rdata), 32'(e));
      cpu_rd = 1'b1;
      exp_q.push_back(ev);
      @(posedge clk);
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic cpu_read();
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         chk("read_underrun", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("head", 32'(cpu_rdata), 32'(e));
      end
      cpu_rd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cpu_rd = 1'b0;
   endtask

   task automatic drain();
      while (exp_q.size() != 0) cpu_read();
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_rdata", 32'(cpu_rdata), 32'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      kb_data  = 8'h00;
      kb_ready = 1'b0;
      cpu_rd   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_rdn", 32'(ps2_rdn), 32'd1);
      chk("rst_rdata", 32'(cpu_rdata), 32'h0000);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);

      // Read on empty is ignored
      cpu_rd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cpu_rd = 1'b0;
      chk("empty_rd_count", 32'(count), 32'd0);
      chk("empty_rd_ovf", 32'(overflow), 32'd0);

      // Single make code
      send_byte(8'h1C);
      exp_q.push_back(16'h801C);
      chk("make_count", 32'(count), 32'd1);
      chk("make_rdata", 32'(cpu_rdata), 32'h801C);
      drain();

      // Extended release
      send_byte(8'hE0);
      chk("e0_count", 32'(count), 32'd0);
      send_byte(8'hF0);
      chk("f0_count", 32'(count), 32'd0);
      send_byte(8'h75);
      exp_q.push_back(16'h8375);
      chk("ext_rel_count", 32'(count), 32'd1);
      drain();

      // Overfill with distinct make codes
      for (int i = 0; i < DEPTH + 1; i++) begin
         send_byte(8'(8'h15 + i));
         if (i < DEPTH) exp_q.push_back(16'h8000 | 16'(8'h15 + i));
         if (i == DEPTH - 1) begin
            chk("full_count", 32'(count), 32'd8);
            chk("full_ovf", 32'(overflow), 32'd0);
         end
      end
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_head", 32'(cpu_rdata), 32'h8015);
      cpu_read();
      chk("ovf_rd_count", 32'(count), 32'd7);
      chk("ovf_rd_flag", 32'(overflow), 32'd0);
      chk("ovf_rd_head", 32'(cpu_rdata), 32'h8016);

      // Refill, then push+pop while full (pointers wrap)
      send_byte(8'h1E);
      exp_q.push_back(16'h801E);
      chk("refill_count", 32'(count), 32'd8);
      send_byte_pop(8'h1F, 16'h801F);
      chk("pp1_count", 32'(count), 32'd8);
      chk("pp1_ovf", 32'(overflow), 32'd0);
      send_byte_pop(8'h20, 16'h8020);
      chk("pp2_count", 32'(count), 32'd8);
      chk("pp2_ovf", 32'(overflow), 32'd0);
      drain();

      // Auto-repeat sequence
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
      exp_q.push_back(16'h801C);
      exp_q.push_back(16'h821C);
      chk("rep_count", 32'(count), 32'd2);
`else
      exp_q.push_back(16'h801C);
      exp_q.push_back(16'h801C);
      exp_q.push_back(16'h801C);
      exp_q.push_back(16'h821C);
      chk("rep_count", 32'(count), 32'd4);
`endif
      drain();

      // Error byte aborts a prefix; E0 restarts a partial sequence
      send_byte(8'hE0);
      send_byte(8'h00);
      send_byte(8'h1C);
      exp_q.push_back(16'h801C);
      send_byte(8'hF0);
      send_byte(8'hE0);
      send_byte(8'h74);
      exp_q.push_back(16'h8174);
      chk("abort_count", 32'(count), 32'd2);
      drain();

      // Reset mid-prefix
      send_byte(8'hE0);
      send_byte(8'hF0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_rdn", 32'(ps2_rdn), 32'd1);
      rst = 1'b0;
      chk("rst_mid_count", 32'(count), 32'd0);
      send_byte(8'h1C);
      exp_q.push_back(16'h801C);
      chk("post_rst_count", 32'(count), 32'd1);
      chk("post_rst_rdata", 32'(cpu_rdata), 32'h801C);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
